// File: rtl/neureka_pres_accumulator.sv
// Shift-accumulates signed bit-plane partial results over N input-channel tiles; MSB plane negated for signed weights.
// Result is valid 1 cycle after the last beat and held until acc_ready_i; input stalls on ~enable_i or outside ACCUM.
module neureka_pres_accumulator #(
  parameter int PRES_WIDTH = 22,
  parameter int ACC_WIDTH  = 32,
  parameter int QW_MAX     = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  enable_i,
  input  logic                  start_i,
  input  logic [3:0]            qw_i,
  input  logic                  signed_w_i,
  input  logic [CNT_WIDTH-1:0]  n_tiles_i,
  input  logic                  pres_valid_i,
  output logic                  pres_ready_o,
  input  logic [PRES_WIDTH-1:0] pres_data_i,
  output logic                  acc_valid_o,
  input  logic                  acc_ready_i,
  output logic [ACC_WIDTH-1:0]  acc_data_o,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_e;

  localparam logic [3:0] QW_MAX_C = 4'(QW_MAX);

  state_e                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q;
  logic [ACC_WIDTH-1:0]   term;
  logic [3:0]             bit_idx_q;
  logic [3:0]             qw_q;
  logic [3:0]             qw_clamped;
  logic [CNT_WIDTH-1:0]   tile_cnt_q;
  logic [CNT_WIDTH-1:0]   n_tiles_q;
  logic                   signed_q;
  logic                   done_q;
  logic                   beat;
  logic                   last_bit;
  logic                   last_beat;
  logic                   out_hs;

  assign pres_ready_o = (state_q == ACCUM) & enable_i;
  assign acc_valid_o  = (state_q == OUTPUT);
  assign busy_o       = (state_q != IDLE);
  assign done_o       = done_q;
  assign acc_data_o   = acc_q;

  assign beat      = pres_valid_i & pres_ready_o;
  assign out_hs    = acc_valid_o & acc_ready_i;
  assign last_bit  = (bit_idx_q == qw_q - 4'd1);
  assign last_beat = last_bit & (tile_cnt_q == n_tiles_q - CNT_WIDTH'(1));

  // Sign-extend first, then weight by the bit-plane position.
  assign term = ACC_WIDTH'($signed(pres_data_i)) << bit_idx_q;

  always_comb begin
    qw_clamped = qw_i;
    if (qw_i == 4'd0) begin
      qw_clamped = 4'd1;
    end else if (qw_i > QW_MAX_C) begin
      qw_clamped = QW_MAX_C;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i)          state_d = ACCUM;
      ACCUM:   if (beat & last_beat) state_d = OUTPUT;
      OUTPUT:  if (out_hs)           state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      bit_idx_q  <= '0;
      tile_cnt_q <= '0;
      qw_q       <= 4'd1;
      n_tiles_q  <= CNT_WIDTH'(1);
      signed_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= out_hs;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            qw_q       <= qw_clamped;
            signed_q   <= signed_w_i;
            n_tiles_q  <= (n_tiles_i == '0) ? CNT_WIDTH'(1) : n_tiles_i;
            acc_q      <= '0;
            bit_idx_q  <= '0;
            tile_cnt_q <= '0;
          end
        end
        ACCUM: begin
          if (beat) begin
            acc_q <= (signed_q && last_bit) ? acc_q - term : acc_q + term;
            if (last_bit) begin
              bit_idx_q  <= '0;
              tile_cnt_q <= tile_cnt_q + CNT_WIDTH'(1);
            end else begin
              bit_idx_q  <= bit_idx_q + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neureka_pres_accumulator.sv
// Randomized bench for neureka_pres_accumulator with a weighted-sum reference model and a scoreboard monitor.
module tb_neureka_pres_accumulator;
  localparam int PW = 22;
  localparam int AW = 32;
  localparam int CW = 16;

  logic          clk_i = 1'b0;
  logic          rst_i, clear_i, enable_i, start_i, signed_w_i;
  logic [3:0]    qw_i;
  logic [CW-1:0] n_tiles_i;
  logic          pres_valid_i, pres_ready_o;
  logic [PW-1:0] pres_data_i;
  logic          acc_valid_o, acc_ready_i, busy_o, done_o;
  logic [AW-1:0] acc_data_o;

  always #5 clk_i = ~clk_i;

  neureka_pres_accumulator #(.PRES_WIDTH(PW), .ACC_WIDTH(AW), .QW_MAX(8), .CNT_WIDTH(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .enable_i(enable_i), .start_i(start_i),
    .qw_i(qw_i), .signed_w_i(signed_w_i), .n_tiles_i(n_tiles_i),
    .pres_valid_i(pres_valid_i), .pres_ready_o(pres_ready_o), .pres_data_i(pres_data_i),
    .acc_valid_o(acc_valid_o), .acc_ready_i(acc_ready_i), .acc_data_o(acc_data_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  logic [AW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int ready_mode = 0;  // 0: random, 1: held low, 2: held high

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    acc_ready_i = 1'b0;
    forever begin
      step();
      case (ready_mode)
        0:       acc_ready_i = 1'($urandom_range(0, 1));
        1:       acc_ready_i = 1'b0;
        default: acc_ready_i = 1'b1;
      endcase
    end
  end

  // Monitor: output beats against the scoreboard, done pulse timing, and hold-stability under backpressure.
  logic          hs, hs_prev = 1'b0, stall_prev = 1'b0;
  logic [AW-1:0] data_prev = '0;
  always @(negedge clk_i) begin
    if (rst_i) begin
      hs_prev    = 1'b0;
      stall_prev = 1'b0;
    end else begin
      chk("done_pulse", {31'b0, done_o}, {31'b0, hs_prev});
      if (stall_prev) begin
        chk("hold_valid", {31'b0, acc_valid_o}, 32'd1);
        chk("hold_data", acc_data_o, data_prev);
      end
      hs = acc_valid_o && acc_ready_i && !clear_i;
      if (hs) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", acc_data_o, ~acc_data_o);
        end else begin
          chk("acc_data", acc_data_o, exp_q.pop_front());
        end
      end
      stall_prev = acc_valid_o && !acc_ready_i && !clear_i;
      data_prev  = acc_data_o;
      hs_prev    = hs;
    end
  end

  task automatic run_job(input logic [3:0] qw, input logic sgn, input logic [CW-1:0] nt,
                         input logic [PW-1:0] beats_in[$], input int abort_after);
    int            qe, ne, total, budget;
    logic [PW-1:0] beats[$];
    longint        sum, w;
    logic          ok;
    qe    = (qw == 0) ? 1 : (qw > 8) ? 8 : int'(qw);
    ne    = (nt == 0) ? 1 : int'(nt);
    total = qe * ne;
    beats = beats_in;
    while (beats.size() < total) beats.push_back(PW'($urandom));

    budget = 0;
    while (busy_o && budget < 2000) begin
      step();
      budget++;
    end
    chk("idle_before_start", {31'b0, busy_o}, 32'd0);

    start_i = 1'b1; qw_i = qw; signed_w_i = sgn; n_tiles_i = nt;
    step();
    start_i = 1'b0;

    for (int i = 0; i < total; i++) begin
      if (abort_after > 0 && i == abort_after) begin
        pres_valid_i = 1'b0; start_i = 1'b0; clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        @(negedge clk_i);
        chk("abort_busy", {31'b0, busy_o}, 32'd0);
        chk("abort_valid", {31'b0, acc_valid_o}, 32'd0);
        step();
        return;
      end
      ok = 1'b0;
      budget = 0;
      while (!ok && budget < 200) begin
        pres_valid_i = ($urandom_range(0, 3) != 0);
        pres_data_i  = pres_valid_i ? beats[i] : PW'($urandom);
        enable_i     = ($urandom_range(0, 3) != 0);
        // Config and start noise mid-job must be ignored.
        start_i      = 1'($urandom_range(0, 1));
        qw_i         = 4'($urandom);
        signed_w_i   = 1'($urandom);
        n_tiles_i    = CW'($urandom);
        @(negedge clk_i);
        chk("ready_vs_enable", {31'b0, pres_ready_o}, {31'b0, enable_i});
        chk("valid_low_in_accum", {31'b0, acc_valid_o}, 32'd0);
        ok = pres_valid_i && pres_ready_o;
        step();
        budget++;
      end
      chk("beat_accepted", {31'b0, ok}, 32'd1);
    end
    pres_valid_i = 1'b0; start_i = 1'b0; enable_i = 1'b1;

    sum = 0;
    for (int t = 0; t < ne; t++) begin
      for (int b = 0; b < qe; b++) begin
        w = longint'(1) << b;
        if (sgn && b == qe - 1) w = -w;
        sum += longint'($signed(beats[t * qe + b])) * w;
      end
    end
    exp_q.push_back(sum[AW-1:0]);

    @(negedge clk_i);
    chk("valid_latency", {31'b0, acc_valid_o}, 32'd1);
    chk("ready_low_in_output", {31'b0, pres_ready_o}, 32'd0);
    step();
  endtask

  initial begin
    logic [PW-1:0] q[$];
    int budget;
    rst_i = 1'b1; clear_i = 1'b0; enable_i = 1'b1; start_i = 1'b0; qw_i = 4'd1;
    signed_w_i = 1'b0; n_tiles_i = '0; pres_valid_i = 1'b0; pres_data_i = '0;
    repeat (3) step();
    @(negedge clk_i);
    chk("rst_acc_valid", {31'b0, acc_valid_o}, 32'd0);
    chk("rst_pres_ready", {31'b0, pres_ready_o}, 32'd0);
    chk("rst_busy", {31'b0, busy_o}, 32'd0);
    chk("rst_done", {31'b0, done_o}, 32'd0);
    chk("rst_acc_data", acc_data_o, 32'd0);
    step();
    rst_i = 1'b0;
    step();
    @(negedge clk_i);
    chk("idle_pres_ready", {31'b0, pres_ready_o}, 32'd0);
    step();

    ready_mode = 0;
    q = {22'd5};                                 run_job(4'd1, 1'b0, 16'd1, q, 0);
    q = {22'd1, 22'd2, 22'd3, 22'd4};            run_job(4'd4, 1'b0, 16'd1, q, 0);
    q = {22'd1, 22'd0, 22'd0, 22'd1};            run_job(4'd4, 1'b1, 16'd1, q, 0);
    q = {22'h3FFFFF, 22'h3FFFFF, 22'h3FFFFF, 22'h3FFFFF};
    run_job(4'd2, 1'b0, 16'd2, q, 0);
    q = {};
    run_job(4'd0, 1'b1, 16'd0, q, 0);
    run_job(4'd15, 1'b1, 16'd1, q, 0);

    ready_mode = 1;
    run_job(4'd3, 1'b1, 16'd2, q, 0);
    repeat (5) begin
      @(negedge clk_i);
      chk("bp_valid", {31'b0, acc_valid_o}, 32'd1);
      chk("bp_pres_ready", {31'b0, pres_ready_o}, 32'd0);
      chk("bp_done", {31'b0, done_o}, 32'd0);
    end
    step();
    ready_mode = 0;

    ready_mode = 2;
    q = {22'd9, 22'd9, 22'd9, 22'd9};            run_job(4'd4, 1'b0, 16'd1, q, 2);
    q = {22'd1, 22'd1, 22'd1, 22'd1};            run_job(4'd4, 1'b0, 16'd1, q, 0);

    q = {};
    for (int j = 0; j < 40; j++) begin
      ready_mode = ($urandom_range(0, 1) == 0) ? 0 : 2;
      run_job(4'($urandom_range(0, 10)), 1'($urandom), CW'($urandom_range(0, 3)), q, 0);
    end

    ready_mode = 2;
    budget = 0;
    while (exp_q.size() > 0 && budget < 2000) begin
      step();
      budget++;
    end
    repeat (3) step();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
